// File: rtl/seg7_msg_sequencer.sv
// seg7_msg_sequencer: serially loaded glyph message player for a common-anode
// 7-segment display. Each glyph is shown for one dwell period, followed by one
// blank dwell, and the message closes with two blank dwells before repeating.
module seg7_msg_sequencer #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 22
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W = PTR_W + 1;

  localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L      = LEN_W'(1);
  localparam logic [LEN_W-1:0] PRESET_LEN = LEN_W'((DEPTH < 5) ? DEPTH : 5);

  localparam logic [2:0] ST_EMPTY = 3'd0;
  localparam logic [2:0] ST_SHOW  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_TAIL  = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  logic       clk;
  logic       rst;
  logic       load;
  logic       pause;
  logic [3:0] data;

  assign clk   = io_in[0];
  assign rst   = io_in[1];
  assign load  = io_in[2];
  assign pause = io_in[3];
  assign data  = io_in[7:4];

  logic [2:0]         state_q, state_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               tail_q, tail_d;
  logic [LEN_W-1:0]   wptr_q, wptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               load_q;
  logic [3:0]         msg_q [DEPTH];
  logic               msg_we;
  logic [PTR_W-1:0]   msg_wa;
  logic [7:0]         out_q, out_d;

  // Active-low segment pattern for a glyph code; DP stays off.
  function automatic logic [7:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'hC6;
      4'hC: glyph = 8'h86;
      4'hD: glyph = 8'h89;
      4'hE: glyph = 8'hC7;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Power-on message "HELL0"; entries beyond it start blank.
  function automatic logic [3:0] preset_code(input int idx);
    case (idx)
      0:       preset_code = 4'hD;
      1:       preset_code = 4'hC;
      2, 3:    preset_code = 4'hE;
      4:       preset_code = 4'h0;
      default: preset_code = 4'hF;
    endcase
  endfunction

  // Next-state logic: load beats pause, pause beats dwell sequencing.
  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    msg_we  = 1'b0;
    msg_wa  = '0;
    if (load) begin
      if (!load_q) begin
        msg_we  = 1'b1;
        msg_wa  = '0;
        len_d   = ONE_L;
        wptr_d  = ONE_L;
        state_d = ST_LOAD;
        cnt_d   = '0;
      end else if (wptr_q < DEPTH_L) begin
        // Writes past the last entry are dropped; no wrap to entry 0.
        msg_we = 1'b1;
        msg_wa = wptr_q[PTR_W-1:0];
        len_d  = wptr_q + ONE_L;
        wptr_d = wptr_q + ONE_L;
      end
    end else if (state_q == ST_LOAD) begin
      state_d = ST_SHOW;
      rptr_d  = '0;
      cnt_d   = '0;
    end else if (!pause) begin
      cnt_d = cnt_q + DWELL_W'(1);
      if (&cnt_q) begin
        case (state_q)
          ST_SHOW: state_d = ST_GAP;
          ST_GAP: begin
            if ((LEN_W'(rptr_q) + ONE_L) < len_q) begin
              rptr_d  = rptr_q + PTR_W'(1);
              state_d = ST_SHOW;
            end else begin
              state_d = ST_TAIL;
              tail_d  = 1'b0;
            end
          end
          ST_TAIL: begin
            if (!tail_q) begin
              tail_d = 1'b1;
            end else begin
              state_d = ST_SHOW;
              rptr_d  = '0;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Display word for the current state; registered below for one clock of latency.
  always_comb begin
    out_d = 8'hFF;
    case (state_q)
      ST_SHOW:                     if (len_q != '0) out_d = glyph(msg_q[rptr_q]);
      ST_LOAD:                     out_d = 8'h7F;
      ST_EMPTY, ST_GAP, ST_TAIL:   out_d = 8'hFF;
      default:                     out_d = 8'hFF;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SHOW;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
      wptr_q  <= '0;
      len_q   <= PRESET_LEN;
      load_q  <= 1'b0;
      out_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      load_q  <= load;
      out_q   <= out_d;
    end
  end

  // Message buffer: reset restores the preset, otherwise one serial write per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) msg_q[i] <= preset_code(i);
    end else if (msg_we) begin
      msg_q[msg_wa] <= data;
    end
  end

  assign io_out = out_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Testbench for seg7_msg_sequencer with a 4-clock dwell: directed vector table,
// an overflow load sequence, and random traffic against a timeline model.
module tb_seg7_msg_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int DWELL = 1 << DW;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       load  = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] data  = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  assign io_in = {data, pause, load, rst, clk};

  seg7_msg_sequencer #(.DEPTH(DEPTH), .DWELL_W(DW)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [16];

  // Reference model: the message as a timeline of clocks since playback start.
  logic [3:0] m_buf [DEPTH];
  int         m_len, m_wptr, m_t;
  bit         m_loading, m_lprev;
  logic [7:0] m_exp;

  function automatic logic [7:0] m_display();
    int per;
    per = m_t / DWELL;
    if (m_loading) return 8'h7F;
    if (per < 2 * m_len && (per % 2) == 0) return rom[m_buf[per / 2]];
    return 8'hFF;
  endfunction

  task automatic m_preset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = 4'hF;
    m_buf[0] = 4'hD; m_buf[1] = 4'hC; m_buf[2] = 4'hE; m_buf[3] = 4'hE; m_buf[4] = 4'h0;
    m_len = 5; m_wptr = 0; m_t = 0; m_loading = 0;
  endtask

  task automatic m_step();
    if (rst) begin
      m_preset();
      m_exp = 8'hFF;
    end else begin
      m_exp = m_display();
      if (load && !m_lprev) begin
        m_buf[0] = data; m_len = 1; m_wptr = 1; m_loading = 1; m_t = 0;
      end else if (load) begin
        if (m_wptr < DEPTH) begin
          m_buf[m_wptr] = data;
          m_wptr++;
          m_len = m_wptr;
        end
      end else if (m_loading) begin
        m_loading = 0; m_t = 0;
      end else if (!pause) begin
        m_t++;
        if (m_t == (2 * m_len + 2) * DWELL) m_t = 0;
      end
    end
    m_lprev = rst ? 1'b0 : load;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    m_step();
    #1;
  endtask

  task automatic check(input logic [7:0] exp, input string name);
    n_vec++;
    if (io_out !== exp) begin
      n_bad++;
      $display("FAIL %s: io_out=%02h expected %02h (cycle %0d)", name, io_out, exp, cyc);
    end
  endtask

  typedef struct {
    bit         r;
    bit         l;
    bit         p;
    logic [3:0] d;
    int         n;
    logic [7:0] e;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit l, input bit p, input logic [3:0] d,
                     input int n, input logic [7:0] e, input string nm);
    vec_t v;
    v.r = r; v.l = l; v.p = p; v.d = d; v.n = n; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    rom = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'hC6, 8'h86, 8'h89, 8'hC7, 8'hFF};
    m_preset();
    m_lprev = 0;
    m_exp   = 8'hFF;

    // Reset, then one full "HELL0" cycle and the start of the next.
    add(1, 0, 0, 4'h0,  2, 8'hFF, "reset");
    add(0, 0, 0, 4'h0,  4, 8'h89, "H");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_H");
    add(0, 0, 0, 4'h0,  4, 8'h86, "E");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_E");
    add(0, 0, 0, 4'h0,  4, 8'hC7, "L1");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_L1");
    add(0, 0, 0, 4'h0,  4, 8'hC7, "L2");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_L2");
    add(0, 0, 0, 4'h0,  4, 8'hC0, "O");
    add(0, 0, 0, 4'h0, 12, 8'hFF, "gap_tail");
    add(0, 0, 0, 4'h0,  4, 8'h89, "H_repeat");
    // Load A, C, blank; DP lit while loading.
    add(0, 1, 0, 4'hA,  1, 8'hFF, "load_first");
    add(0, 1, 0, 4'hB,  1, 8'h7F, "load_dp");
    add(0, 1, 0, 4'hF,  1, 8'h7F, "load_dp");
    add(0, 0, 0, 4'h0,  1, 8'h7F, "load_exit");
    add(0, 0, 0, 4'h0,  4, 8'h88, "A");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_A");
    add(0, 0, 0, 4'h0,  4, 8'hC6, "C");
    add(0, 0, 0, 4'h0, 20, 8'hFF, "blank_gap_tail");
    add(0, 0, 0, 4'h0,  4, 8'h88, "A_repeat");
    // Pause during the first 'H' stretches it by the paused clocks.
    add(1, 0, 0, 4'h0,  1, 8'hFF, "reset2");
    add(0, 0, 0, 4'h0,  2, 8'h89, "H_pre_pause");
    add(0, 0, 1, 4'h0,  5, 8'h89, "H_paused");
    add(0, 0, 0, 4'h0,  2, 8'h89, "H_resume");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_after_pause");
    add(0, 0, 0, 4'h0,  4, 8'h86, "E_after_pause");
    // Reset in the middle of a load brings "HELL0" back.
    add(0, 1, 0, 4'h3,  1, 8'hFF, "midload_first");
    add(0, 1, 0, 4'h4,  1, 8'h7F, "midload_dp");
    add(1, 1, 0, 4'h5,  1, 8'hFF, "reset_midload");
    add(0, 0, 0, 4'h0,  4, 8'h89, "H_after_reset");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_after_reset");
    add(0, 0, 0, 4'h0,  4, 8'h86, "E_preset");
    add(0, 0, 0, 4'h0,  4, 8'hFF, "gap_E2");
    add(0, 0, 0, 4'h0,  2, 8'hC7, "L1_part");
    // Load and pause together in SHOW: load wins.
    add(0, 1, 1, 4'h9,  1, 8'hC7, "load_pause");
    add(0, 0, 1, 4'h0,  1, 8'h7F, "load_wins");
    add(0, 0, 0, 4'h0,  4, 8'h90, "nine");
    add(0, 0, 0, 4'h0, 12, 8'hFF, "nine_gap_tail");
    add(0, 0, 0, 4'h0,  4, 8'h90, "nine_repeat");

    foreach (tbl[j]) begin
      for (int k = 0; k < tbl[j].n; k++) begin
        rst = tbl[j].r; load = tbl[j].l; pause = tbl[j].p; data = tbl[j].d;
        tick();
        check(tbl[j].e, tbl[j].nm);
      end
    end

    // Overflow: ten codes into an eight-entry buffer, digits 0..7 play back.
    rst = 0; pause = 0;
    for (int i = 0; i < 10; i++) begin
      load = 1; data = 4'(i);
      tick();
      check((i == 0) ? 8'hFF : 8'h7F, "ovf_load");
    end
    load = 0; data = 4'h0;
    tick();
    check(8'h7F, "ovf_exit");
    for (int k = 0; k < DEPTH; k++) begin
      for (int c = 0; c < DWELL; c++) begin tick(); check(rom[k], "ovf_digit"); end
      for (int c = 0; c < DWELL; c++) begin tick(); check(8'hFF, "ovf_gap"); end
    end
    for (int c = 0; c < 2 * DWELL; c++) begin tick(); check(8'hFF, "ovf_tail"); end
    for (int c = 0; c < DWELL; c++) begin tick(); check(rom[0], "ovf_repeat"); end

    // Random traffic against the model.
    rst = 1; load = 0; pause = 0;
    tick();
    check(m_exp, "random_reset");
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (load) load = ($urandom_range(0, 5) != 0);
      else      load = ($urandom_range(0, 39) == 0);
      if (pause) pause = ($urandom_range(0, 3) != 0);
      else       pause = ($urandom_range(0, 15) == 0);
      data = 4'($urandom);
      tick();
      check(m_exp, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
